pc_stack: RTL and testbench

Return-address stack for the MUSA IF stage. It sits directly upstream of the PC select mux and drives that mux's stack-source PC input. On a CALL it pushes the sequential PC (PC+1). On a RET it pops, and the popped address is presented combinationally so the mux can select it in the same cycle the RET is decoded. It also reports occupancy and sticky overflow/underflow error flags to the control unit.

---
 rtl/musa_if_pkg.sv | 16 +
 rtl/pc_stack_ram.sv | 26 ++
 rtl/pc_stack.sv | 115 +++++++++++
 tb/tb_pc_stack.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/musa_if_pkg.sv
// Shared MUSA IF-stage definitions: PC width, return-address stack sizing
// and the PC select mux source encodings.
package musa_if_pkg;

  localparam int PC_WIDTH      = 32;
  localparam int RAS_DEPTH     = 16;
  localparam int RAS_PTR_WIDTH = 4;

  typedef enum logic [1:0] {
    PC_SRC_STACK  = 2'b00,
    PC_SRC_SEQ    = 2'b01,
    PC_SRC_BRANCH = 2'b10,
    PC_SRC_JUMP   = 2'b11
  } pc_src_e;

endpackage

// File: rtl/pc_stack_ram.sv
// Return-address storage: register array with one synchronous write port
// and one asynchronous read port. Contents survive reset.
module pc_stack_ram
  import musa_if_pkg::*;
#(
  parameter int DATA_WIDTH = PC_WIDTH,
  parameter int DEPTH      = RAS_DEPTH,
  parameter int PTR_WIDTH  = RAS_PTR_WIDTH
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [PTR_WIDTH-1:0]  waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [PTR_WIDTH-1:0]  raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/pc_stack.sv
// Return-address stack for the IF stage: pointer and sticky error flag
// logic around pc_stack_ram, with top_data forced to zero while empty.
module pc_stack
  import musa_if_pkg::*;
#(
  parameter int DATA_WIDTH = PC_WIDTH,
  parameter int DEPTH      = RAS_DEPTH,
  parameter int PTR_WIDTH  = RAS_PTR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  clear_err,
  output logic [DATA_WIDTH-1:0] top_data,
  output logic [PTR_WIDTH:0]    count,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [PTR_WIDTH:0]   FULL_COUNT = (PTR_WIDTH + 1)'(DEPTH);
  localparam logic [PTR_WIDTH:0]   COUNT_ONE  = (PTR_WIDTH + 1)'(1);
  localparam logic [PTR_WIDTH-1:0] IDX_ONE    = PTR_WIDTH'(1);

  logic [PTR_WIDTH:0]    count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  isEmpty, isFull;
  logic                  ramWe;
  logic [PTR_WIDTH-1:0]  ramWaddr;
  logic [PTR_WIDTH-1:0]  topIdx;
  logic [DATA_WIDTH-1:0] ramRdata;
  logic                  ovfSet, unfSet;

  assign isEmpty = (count_q == '0);
  assign isFull  = (count_q == FULL_COUNT);
  // Low bits of count-1 wrap correctly for count==DEPTH; count==0 is masked below.
  assign topIdx  = count_q[PTR_WIDTH-1:0] - IDX_ONE;

  always_comb begin
    count_d  = count_q;
    ramWe    = 1'b0;
    ramWaddr = count_q[PTR_WIDTH-1:0];
    ovfSet   = 1'b0;
    unfSet   = 1'b0;
    if (!stall) begin
      if (push && pop) begin
        ramWe = 1'b1;
        if (isEmpty) begin
          count_d = COUNT_ONE;
          unfSet  = 1'b1;
        end else begin
          ramWaddr = topIdx;
        end
      end else if (push) begin
        if (isFull) begin
          ovfSet = 1'b1;
        end else begin
          ramWe   = 1'b1;
          count_d = count_q + COUNT_ONE;
        end
      end else if (pop) begin
        if (isEmpty) unfSet = 1'b1;
        else         count_d = count_q - COUNT_ONE;
      end
    end
  end

  // A freshly raised error takes priority over a same-edge clear.
  always_comb begin
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (!stall) begin
      overflow_d  = ovfSet | (overflow_q  & ~clear_err);
      underflow_d = unfSet | (underflow_q & ~clear_err);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  pc_stack_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .PTR_WIDTH  (PTR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (ramWe),
    .waddr (ramWaddr),
    .wdata (push_data),
    .raddr (topIdx),
    .rdata (ramRdata)
  );

  assign top_data  = isEmpty ? '0 : ramRdata;
  assign count     = count_q;
  assign empty     = isEmpty;
  assign full      = isFull;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_pc_stack.sv
// Self-checking bench for pc_stack: directed scenarios plus randomized
// traffic compared against a queue-based model of a LIFO stack.
module tb_pc_stack;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int PW    = 4;

  logic          clk;
  logic          rst_n;
  logic          stall;
  logic          push;
  logic          pop;
  logic [DW-1:0] push_data;
  logic          clear_err;
  logic [DW-1:0] top_data;
  logic [PW:0]   count;
  logic          empty;
  logic          full;
  logic          overflow;
  logic          underflow;

  int errorCount = 0;
  int checkCount = 0;

  logic [DW-1:0] modelStack[$];
  logic          modelOvf;
  logic          modelUnf;

  pc_stack dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .stall     (stall),
    .push      (push),
    .pop       (pop),
    .push_data (push_data),
    .clear_err (clear_err),
    .top_data  (top_data),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag);
    int sz;
    sz = modelStack.size();
    checkOutput({tag, " count"}, 64'(count), 64'(sz));
    checkOutput({tag, " top"}, 64'(top_data), (sz > 0) ? 64'(modelStack[sz-1]) : 64'd0);
    checkOutput({tag, " empty"}, 64'(empty), 64'(sz == 0));
    checkOutput({tag, " full"}, 64'(full), 64'(sz == DEPTH));
    checkOutput({tag, " overflow"}, 64'(overflow), 64'(modelOvf));
    checkOutput({tag, " underflow"}, 64'(underflow), 64'(modelUnf));
  endtask

  task automatic modelReset();
    modelStack.delete();
    modelOvf = 1'b0;
    modelUnf = 1'b0;
  endtask

  task automatic modelStep(input logic p, input logic q, input logic [DW-1:0] d,
                           input logic clr, input logic stl);
    logic newOvf, newUnf;
    int   sz;
    if (stl) return;
    sz     = modelStack.size();
    newUnf = q && (sz == 0);
    newOvf = p && !q && (sz == DEPTH);
    if (p && q) begin
      if (sz == 0) modelStack.push_back(d);
      else         modelStack[sz-1] = d;
    end else if (p) begin
      if (sz < DEPTH) modelStack.push_back(d);
    end else if (q) begin
      if (sz > 0) void'(modelStack.pop_back());
    end
    modelOvf = newOvf | (modelOvf & !clr);
    modelUnf = newUnf | (modelUnf & !clr);
  endtask

  task automatic applyStimulus(input logic p, input logic q, input logic [DW-1:0] d,
                               input logic clr, input logic stl, input string tag);
    @(negedge clk);
    push      = p;
    pop       = q;
    push_data = d;
    clear_err = clr;
    stall     = stl;
    @(posedge clk);
    modelStep(p, q, d, clr, stl);
    #1;
    checkAll(tag);
  endtask

  task automatic asyncReset(input string tag);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    modelReset();
    #1;
    checkAll(tag);
    @(negedge clk);
    push      = 1'b0;
    pop       = 1'b0;
    clear_err = 1'b0;
    stall     = 1'b0;
    rst_n     = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    stall     = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    push_data = '0;
    clear_err = 1'b0;
    modelReset();
    #12;
    checkAll("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Mid-cycle async reset after some activity, then first push.
    applyStimulus(1, 0, 32'h55, 0, 0, "pre");
    applyStimulus(0, 1, 32'h0, 0, 0, "pre");
    applyStimulus(0, 1, 32'h0, 0, 0, "preunf");
    asyncReset("rst1");
    applyStimulus(1, 0, 32'h10, 0, 0, "t1push");

    // LIFO ordering.
    asyncReset("rst2");
    applyStimulus(1, 0, 32'h100, 0, 0, "t2a");
    applyStimulus(1, 0, 32'h200, 0, 0, "t2b");
    applyStimulus(1, 0, 32'h300, 0, 0, "t2c");
    applyStimulus(0, 1, 32'h0, 0, 0, "t2d");
    applyStimulus(0, 1, 32'h0, 0, 0, "t2e");

    // Fill, overflow, replace-when-full, then clear racing a new overflow.
    asyncReset("rst3");
    for (int i = 1; i <= DEPTH; i++) applyStimulus(1, 0, DW'(i), 0, 0, "t3fill");
    applyStimulus(1, 0, 32'hDEAD, 0, 0, "t3ovf");
    applyStimulus(1, 1, 32'hBEEF, 0, 0, "t3repl");
    applyStimulus(1, 0, 32'hCAFE, 1, 0, "t6clrovf");
    applyStimulus(0, 0, 32'h0, 1, 0, "t6clr");

    // Underflow, clear, push+pop on empty.
    asyncReset("rst4");
    applyStimulus(0, 1, 32'h0, 0, 0, "t4unf");
    applyStimulus(0, 0, 32'h0, 1, 0, "t4clr");
    applyStimulus(1, 1, 32'h44, 0, 0, "t4pp");

    // Stall freezes everything, including clear_err.
    asyncReset("rst5");
    applyStimulus(0, 1, 32'h0, 0, 0, "t5unf");
    applyStimulus(1, 0, 32'h10, 0, 0, "t5a");
    applyStimulus(1, 0, 32'h20, 0, 0, "t5b");
    applyStimulus(1, 0, 32'h99, 0, 1, "t5stpush");
    applyStimulus(0, 1, 32'h0, 0, 1, "t5stpop");
    applyStimulus(0, 0, 32'h0, 1, 1, "t5stclr");
    applyStimulus(1, 1, 32'h77, 1, 1, "t5stall");

    // Randomized traffic: push-heavy phase, then pop-heavy phase.
    asyncReset("rst6");
    for (int i = 0; i < 400; i++) begin
      logic p, q, c, s;
      int   pushBias;
      pushBias = (i < 200) ? 70 : 25;
      p = ($urandom_range(99) < pushBias);
      q = ($urandom_range(99) < (100 - pushBias));
      c = ($urandom_range(99) < 8);
      s = ($urandom_range(99) < 10);
      applyStimulus(p, q, $urandom, c, s, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
